// File: rtl/memory_pkg.sv
// Shared memory-map constants, access enums and the access-legality check
// used by the unified-memory arbiter.
package memory_pkg;

  localparam int unsigned MEM_BYTES_DEF  = 2 ** 16;
  localparam int unsigned IMEM_BYTES_DEF = 2 ** 14;
  localparam logic [31:0] IMEM_BASE      = 32'h0000_0000;
  localparam logic [31:0] DMEM_BASE      = 32'h0000_4000;
  localparam int unsigned ERR_ENUMS_WIDTH = 2;

  typedef enum logic [1:0] {
    MEM_WORD = 2'b00,
    MEM_BYTE = 2'b01,
    MEM_HALF = 2'b10,
    MEM_RSVD = 2'b11
  } e_mem_num_bytes;

  typedef enum logic [ERR_ENUMS_WIDTH-1:0] {
    ERR_NONE         = 2'b00,
    ERR_MISALIGNED   = 2'b01,
    ERR_OUT_OF_RANGE = 2'b10,
    ERR_IMEM_WRITE   = 2'b11
  } e_mem_err;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } e_arb_state;

  // Checks are evaluated in priority order: alignment, range, IMEM write.
  function automatic e_mem_err check_access(input logic [31:0]    addr,
                                            input e_mem_num_bytes nb,
                                            input logic           we,
                                            input logic [31:0]    mem_bytes,
                                            input logic [31:0]    imem_bytes);
    e_mem_err err;
    err = ERR_NONE;
    if ((nb == MEM_RSVD) ||
        ((nb == MEM_WORD) && (addr[1:0] != 2'b00)) ||
        ((nb == MEM_HALF) && addr[0])) begin
      err = ERR_MISALIGNED;
    end else if (addr >= mem_bytes) begin
      err = ERR_OUT_OF_RANGE;
    end else if (we && (addr < imem_bytes)) begin
      err = ERR_IMEM_WRITE;
    end
    return err;
  endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Byte-lane steering: byte enables and replicated write data for stores,
// lane selection plus sign/zero extension for loads.
module mem_lane_steer
  import memory_pkg::*;
(
  input  e_mem_num_bytes n_bytes,
  input  logic [1:0]     addr_lo,
  input  logic           is_unsigned,
  input  logic [31:0]    wdata_in,
  input  logic [31:0]    rdata_in,
  output logic [3:0]     be,
  output logic [31:0]    wdata_out,
  output logic [31:0]    load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store side: enables shifted to the addressed lane, data replicated across lanes.
  always_comb begin
    be        = 4'b0000;
    wdata_out = 32'h0;
    case (n_bytes)
      MEM_WORD: begin
        be        = 4'b1111;
        wdata_out = wdata_in;
      end
      MEM_HALF: begin
        be        = 4'b0011 << addr_lo;
        wdata_out = {2{wdata_in[15:0]}};
      end
      MEM_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_out = {4{wdata_in[7:0]}};
      end
      default: begin
        be        = 4'b0000;
        wdata_out = 32'h0;
      end
    endcase
  end

  // Load side: pick the addressed lane and extend to 32 bits.
  always_comb begin
    byte_sel  = 8'h0;
    half_sel  = addr_lo[1] ? rdata_in[31:16] : rdata_in[15:0];
    load_data = 32'h0;
    case (addr_lo)
      2'd0: byte_sel = rdata_in[7:0];
      2'd1: byte_sel = rdata_in[15:8];
      2'd2: byte_sel = rdata_in[23:16];
      default: byte_sel = rdata_in[31:24];
    endcase
    case (n_bytes)
      MEM_WORD: load_data = rdata_in;
      MEM_HALF: load_data = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      MEM_BYTE: load_data = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      default:  load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Round-robin arbiter between instruction fetch and the load/store unit for
// the single-port unified memory. One transaction in flight at a time.
//
// state     | meaning
// ST_IDLE   | waiting; grant issued combinationally, op latched and checked
// ST_ACCESS | memory strobe asserted for one cycle with latched controls
// ST_RESP   | rvalid/done pulse; read data formatted from mem_rdata
module mem_access_arbiter
  import memory_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = MEM_BYTES_DEF,
  parameter int unsigned IMEM_BYTES = IMEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [1:0]  ls_n_bytes,
  input  logic        ls_unsigned,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic [1:0]  ls_err_code,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  e_arb_state     state;
  logic           rr_ls;        // 0: IF owns the pointer, 1: LS owns it
  logic           lat_we;
  logic [1:0]     lat_addr_lo;
  logic           lat_unsigned;
  e_mem_num_bytes lat_nb;
  e_mem_err       lat_err;

  logic           is_idle;
  logic [31:0]    sel_addr;
  e_mem_num_bytes sel_nb;
  logic           sel_we;
  logic           sel_unsigned;
  e_mem_err       sel_err;

  e_mem_num_bytes steer_nb;
  logic [1:0]     steer_addr_lo;
  logic           steer_unsigned;
  logic [3:0]     steer_be;
  logic [31:0]    steer_wdata;
  logic [31:0]    steer_load;

  assign is_idle = (state == ST_IDLE);
  assign if_gnt  = is_idle && if_req && (!ls_req || !rr_ls);
  assign ls_gnt  = is_idle && ls_req && (!if_req || rr_ls);

  // Operation presented by the winner; fetches are always word reads.
  always_comb begin
    sel_addr     = ls_gnt ? ls_addr : if_addr;
    sel_nb       = ls_gnt ? e_mem_num_bytes'(ls_n_bytes) : MEM_WORD;
    sel_we       = ls_gnt && ls_we;
    sel_unsigned = ls_gnt && ls_unsigned;
    sel_err      = check_access(sel_addr, sel_nb, sel_we, 32'(MEM_BYTES), 32'(IMEM_BYTES));
  end

  // The steering block serves the incoming op in IDLE and the latched op afterwards.
  always_comb begin
    steer_nb       = is_idle ? sel_nb : lat_nb;
    steer_addr_lo  = is_idle ? sel_addr[1:0] : lat_addr_lo;
    steer_unsigned = is_idle ? sel_unsigned : lat_unsigned;
  end

  mem_lane_steer u_steer (
    .n_bytes     (steer_nb),
    .addr_lo     (steer_addr_lo),
    .is_unsigned (steer_unsigned),
    .wdata_in    (ls_wdata),
    .rdata_in    (mem_rdata),
    .be          (steer_be),
    .wdata_out   (steer_wdata),
    .load_data   (steer_load)
  );

  // Read data is only meaningful during the response pulse of a good read.
  assign if_rdata = (if_rvalid && !if_err) ? mem_rdata : 32'h0;
  assign ls_rdata = (ls_done && !lat_we && (lat_err == ERR_NONE)) ? steer_load : 32'h0;

  // Arbitration FSM with registered memory strobe and response pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      rr_ls        <= 1'b0;
      lat_we       <= 1'b0;
      lat_addr_lo  <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_nb       <= MEM_WORD;
      lat_err      <= ERR_NONE;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= 4'b0000;
      mem_addr     <= 32'h0;
      mem_wdata    <= 32'h0;
      if_rvalid    <= 1'b0;
      if_err       <= 1'b0;
      ls_done      <= 1'b0;
      ls_err_code  <= 2'b00;
    end else begin
      if_rvalid   <= 1'b0;
      if_err      <= 1'b0;
      ls_done     <= 1'b0;
      ls_err_code <= 2'b00;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= 4'b0000;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      case (state)
        ST_IDLE: begin
          if (if_gnt || ls_gnt) begin
            rr_ls        <= if_gnt;
            lat_we       <= sel_we;
            lat_addr_lo  <= sel_addr[1:0];
            lat_unsigned <= sel_unsigned;
            lat_nb       <= sel_nb;
            lat_err      <= sel_err;
            if (sel_err != ERR_NONE) begin
              // Faulted requests skip the memory entirely.
              state <= ST_RESP;
              if (ls_gnt) begin
                ls_done     <= 1'b1;
                ls_err_code <= sel_err;
              end else begin
                if_rvalid <= 1'b1;
                if_err    <= 1'b1;
              end
            end else begin
              state     <= ST_ACCESS;
              mem_en    <= 1'b1;
              mem_we    <= sel_we;
              mem_be    <= steer_be;
              mem_addr  <= {sel_addr[31:2], 2'b00};
              mem_wdata <= sel_we ? steer_wdata : 32'h0;
            end
          end
        end
        ST_ACCESS: begin
          state <= ST_RESP;
          if (rr_ls) begin
            if_rvalid <= 1'b1;
          end else begin
            ls_done <= 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter: single LS/IF transactions, access
// faults, round-robin alternation and reset in the middle of an access.
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = 32'h0;
  logic [1:0]  ls_n_bytes = 2'b00;
  logic        ls_unsigned = 1'b0;
  logic [31:0] ls_wdata = 32'h0;
  logic        ls_gnt, ls_done;
  logic [31:0] ls_rdata;
  logic [1:0]  ls_err_code;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  mem_access_arbiter dut (
    .clk(clk), .rstn(rstn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_n_bytes(ls_n_bytes),
    .ls_unsigned(ls_unsigned), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_done(ls_done),
    .ls_rdata(ls_rdata), .ls_err_code(ls_err_code),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the request driven; returns at negedge+1 of the grant cycle.
  task automatic wait_gnt(input logic is_ls, input string tag);
    int  k;
    logic got;
    k = 0;
    got = 1'b0;
    #1;
    while (!got && k < 8) begin
      if (is_ls ? ls_gnt : if_gnt) got = 1'b1;
      else begin
        @(negedge clk);
        #1;
        k++;
      end
    end
    chk({tag, "_gnt"}, {31'h0, got}, 32'h1);
    chk({tag, "_excl"}, {31'h0, if_gnt & ls_gnt}, 32'h0);
  endtask

  task automatic drive_ls(input logic we, input logic [31:0] addr, input logic [1:0] nb,
                          input logic uns, input logic [31:0] wd);
    ls_we = we; ls_addr = addr; ls_n_bytes = nb; ls_unsigned = uns; ls_wdata = wd;
    ls_req = 1'b1;
  endtask

  // Full good LS transaction: gnt, ACCESS checks, RESP checks.
  task automatic ls_good(input string tag, input logic we, input logic [31:0] addr,
                         input logic [1:0] nb, input logic uns, input logic [31:0] wd,
                         input logic [31:0] rd, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    @(negedge clk);
    drive_ls(we, addr, nb, uns, wd);
    wait_gnt(1'b1, tag);
    @(negedge clk);
    ls_req = 1'b0;
    mem_rdata = rd;
    #1;
    chk({tag, "_en"}, {31'h0, mem_en}, 32'h1);
    chk({tag, "_we"}, {31'h0, mem_we}, {31'h0, we});
    chk({tag, "_be"}, {28'h0, mem_be}, {28'h0, exp_be});
    chk({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
    if (we) chk({tag, "_wdata"}, mem_wdata, exp_wd);
    chk({tag, "_early_done"}, {31'h0, ls_done}, 32'h0);
    @(negedge clk);
    #1;
    chk({tag, "_done"}, {31'h0, ls_done}, 32'h1);
    chk({tag, "_rdata"}, ls_rdata, exp_rd);
    chk({tag, "_code"}, {30'h0, ls_err_code}, 32'h0);
    @(negedge clk);
  endtask

  // Faulting LS request: done one cycle after gnt, no memory strobe.
  task automatic ls_fault(input string tag, input logic we, input logic [31:0] addr,
                          input logic [1:0] nb, input logic [1:0] exp_code);
    @(negedge clk);
    drive_ls(we, addr, nb, 1'b0, 32'hCAFE_F00D);
    wait_gnt(1'b1, tag);
    @(negedge clk);
    ls_req = 1'b0;
    #1;
    chk({tag, "_en"}, {31'h0, mem_en}, 32'h0);
    chk({tag, "_done"}, {31'h0, ls_done}, 32'h1);
    chk({tag, "_code"}, {30'h0, ls_err_code}, {30'h0, exp_code});
    chk({tag, "_rdata"}, ls_rdata, 32'h0);
    @(negedge clk);
    #1;
    chk({tag, "_en2"}, {31'h0, mem_en}, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_ls;
    int   ngr;
    int   cyc;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_ls_done", {31'h0, ls_done}, 32'h0);
    chk("rst_if_rvalid", {31'h0, if_rvalid}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_gnts", {30'h0, if_gnt, ls_gnt}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("post_rst_gnts", {30'h0, if_gnt, ls_gnt}, 32'h0);
    chk("post_rst_rdata", ls_rdata | if_rdata, 32'h0);

    // Loads and stores
    ls_good("lw4000", 1'b0, 32'h4000, 2'b00, 1'b0, 32'h0, 32'hDEADBEEF, 4'b1111, 32'h0, 32'hDEADBEEF);
    ls_good("lb4003", 1'b0, 32'h4003, 2'b01, 1'b0, 32'h0, 32'h80123456, 4'b1000, 32'h0, 32'hFFFFFF80);
    ls_good("lbu4003", 1'b0, 32'h4003, 2'b01, 1'b1, 32'h0, 32'h80123456, 4'b1000, 32'h0, 32'h00000080);
    ls_good("lh4002", 1'b0, 32'h4002, 2'b10, 1'b0, 32'h0, 32'h9ABC1234, 4'b1100, 32'h0, 32'hFFFF9ABC);
    ls_good("lhu4000", 1'b0, 32'h4000, 2'b10, 1'b1, 32'h0, 32'h1234F00D, 4'b0011, 32'h0, 32'h0000F00D);
    ls_good("lb4001", 1'b0, 32'h4001, 2'b01, 1'b0, 32'h0, 32'h00007F00, 4'b0010, 32'h0, 32'h0000007F);
    ls_good("sh4002", 1'b1, 32'h4002, 2'b10, 1'b0, 32'h1234ABCD, 32'h0, 4'b1100, 32'hABCDABCD, 32'h0);
    ls_good("sb4005", 1'b1, 32'h4005, 2'b01, 1'b0, 32'h000000A5, 32'h0, 4'b0010, 32'hA5A5A5A5, 32'h0);
    ls_good("swfffc", 1'b1, 32'hFFFC, 2'b00, 1'b0, 32'h11223344, 32'h0, 4'b1111, 32'h11223344, 32'h0);

    // Faults
    ls_fault("lh4001", 1'b0, 32'h4001, 2'b10, 2'b01);
    ls_fault("sw0100", 1'b1, 32'h0100, 2'b00, 2'b11);
    ls_fault("lw10000", 1'b0, 32'h10000, 2'b00, 2'b10);
    ls_fault("rsvd4000", 1'b0, 32'h4000, 2'b11, 2'b01);
    ls_fault("sw3ffc", 1'b1, 32'h3FFC, 2'b00, 2'b11);

    // Fetch fault
    @(negedge clk);
    if_addr = 32'h0002;
    if_req = 1'b1;
    wait_gnt(1'b0, "if0002");
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("if0002_en", {31'h0, mem_en}, 32'h0);
    chk("if0002_rvalid", {31'h0, if_rvalid}, 32'h1);
    chk("if0002_err", {31'h0, if_err}, 32'h1);
    chk("if0002_rdata", if_rdata, 32'h0);
    @(negedge clk);

    // Good fetch
    @(negedge clk);
    if_addr = 32'h0010;
    if_req = 1'b1;
    wait_gnt(1'b0, "if0010");
    @(negedge clk);
    if_req = 1'b0;
    mem_rdata = 32'h00A0_0513;
    #1;
    chk("if0010_en", {31'h0, mem_en}, 32'h1);
    chk("if0010_addr", mem_addr, 32'h0010);
    chk("if0010_be", {28'h0, mem_be}, 32'hF);
    @(negedge clk);
    #1;
    chk("if0010_rvalid", {31'h0, if_rvalid}, 32'h1);
    chk("if0010_err", {31'h0, if_err}, 32'h0);
    chk("if0010_rdata", if_rdata, 32'h00A0_0513);
    chk("if0010_ls_done", {31'h0, ls_done}, 32'h0);
    @(negedge clk);

    // Reset during ACCESS; leave the pointer at LS first by granting IF last above
    @(negedge clk);
    drive_ls(1'b0, 32'h4000, 2'b00, 1'b0, 32'h0);
    wait_gnt(1'b1, "rstmid");
    @(negedge clk);
    #1;
    chk("rstmid_en_before", {31'h0, mem_en}, 32'h1);
    rstn = 1'b0;
    ls_req = 1'b0;
    #1;
    chk("rstmid_en", {31'h0, mem_en}, 32'h0);
    @(negedge clk);
    #1;
    chk("rstmid_done", {31'h0, ls_done}, 32'h0);
    chk("rstmid_rvalid", {31'h0, if_rvalid}, 32'h0);
    chk("rstmid_en2", {31'h0, mem_en}, 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    // Round-robin with both requests held continuously
    @(negedge clk);
    if_addr = 32'h0020;
    if_req = 1'b1;
    drive_ls(1'b0, 32'h4008, 2'b00, 1'b0, 32'h0);
    exp_ls = 1'b0;
    ngr = 0;
    cyc = 0;
    while (ngr < 4 && cyc < 40) begin
      #1;
      if (if_gnt || ls_gnt) begin
        chk($sformatf("alt%0d_excl", ngr), {31'h0, if_gnt & ls_gnt}, 32'h0);
        chk($sformatf("alt%0d_ls", ngr), {31'h0, ls_gnt}, {31'h0, exp_ls});
        exp_ls = ~exp_ls;
        ngr++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("alt_count", ngr, 4);
    if_req = 1'b0;
    ls_req = 1'b0;
    repeat (3) @(negedge clk);

    // Fresh transaction after everything above
    ls_good("lw4004", 1'b0, 32'h4004, 2'b00, 1'b0, 32'h0, 32'h0BADF00D, 4'b1111, 32'h0, 32'h0BADF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
